// File: rtl/io_port_bank.sv
// Memory-mapped bank of NCH GPIO channels: OUT, IN, sticky EDGE and MASK registers per channel.
// Define IO_PORT_BANK_EDGE_IRQ_EN to build edge detection, EDGE/MASK registers and the irq output.
module io_port_bank #(
    parameter int          WIDTH = 8,
    parameter int          NCH   = 4,
    parameter logic [31:0] BASE  = 32'h800
) (
    input  logic                 clk,
    input  logic                 resetE,
    input  logic                 we,
    input  logic                 re,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 sel,
    input  logic [NCH*WIDTH-1:0] pin_in,
    output logic [NCH*WIDTH-1:0] pin_out,
    output logic                 irq
);

    localparam int          CHW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int          BW       = NCH * WIDTH;
    localparam logic [31:0] WIN_LAST = BASE + 32'(16 * NCH) - 32'd1;

    logic [CHW-1:0]   chIdx;
    logic [1:0]       regOff;
    logic             wrEn;
    logic [BW-1:0]    s1Q, s2Q;
    logic [BW-1:0]    outQ, outD;
    logic [WIDTH-1:0] rdSel;
    logic             unusedBits;

    // Reads have no side effects, so the load strobe is not needed for decoding.
    assign unusedBits = ^{re, wdata};

    assign sel    = (addr >= BASE) && (addr <= WIN_LAST);
    assign regOff = addr[3:2];
    assign wrEn   = we & sel;

    generate
        if (NCH > 1) begin : gMultiCh
            assign chIdx = addr[4 +: CHW];
        end else begin : gSingleCh
            assign chIdx = '0;
        end
    endgenerate

    always_comb begin
        outD = outQ;
        for (int ch = 0; ch < NCH; ch++) begin
            if (wrEn && (regOff == 2'd0) && (chIdx == CHW'(ch))) begin
                outD[ch*WIDTH +: WIDTH] = wdata[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge resetE) begin
        if (!resetE) begin
            s1Q  <= '0;
            s2Q  <= '0;
            outQ <= '0;
        end else begin
            s1Q  <= pin_in;
            s2Q  <= s1Q;
            outQ <= outD;
        end
    end

    assign pin_out = outQ;

`ifdef IO_PORT_BANK_EDGE_IRQ_EN
    logic [BW-1:0] s3Q;
    logic [BW-1:0] edgeQ, edgeD;
    logic [BW-1:0] maskQ, maskD;
    logic [BW-1:0] clrVec;
    logic          irqQ;

    // The rising-edge term is ORed in last so a new edge beats a simultaneous W1C.
    always_comb begin
        maskD  = maskQ;
        clrVec = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (wrEn && (chIdx == CHW'(ch))) begin
                if (regOff == 2'd2) begin
                    clrVec[ch*WIDTH +: WIDTH] = wdata[WIDTH-1:0];
                end
                if (regOff == 2'd3) begin
                    maskD[ch*WIDTH +: WIDTH] = wdata[WIDTH-1:0];
                end
            end
        end
        edgeD = (edgeQ & ~clrVec) | (s2Q & ~s3Q);
    end

    always_ff @(posedge clk or negedge resetE) begin
        if (!resetE) begin
            s3Q   <= '0;
            edgeQ <= '0;
            maskQ <= '0;
            irqQ  <= 1'b0;
        end else begin
            s3Q   <= s2Q;
            edgeQ <= edgeD;
            maskQ <= maskD;
            irqQ  <= |(edgeQ & maskQ);
        end
    end

    assign irq = irqQ;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdSel = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (chIdx == CHW'(ch)) begin
                case (regOff)
                    2'd0:    rdSel = outQ[ch*WIDTH +: WIDTH];
                    2'd1:    rdSel = s2Q[ch*WIDTH +: WIDTH];
`ifdef IO_PORT_BANK_EDGE_IRQ_EN
                    2'd2:    rdSel = edgeQ[ch*WIDTH +: WIDTH];
                    2'd3:    rdSel = maskQ[ch*WIDTH +: WIDTH];
`endif
                    default: rdSel = '0;
                endcase
            end
        end
    end

    assign rdata = sel ? 32'(rdSel) : 32'd0;

endmodule

// File: tb/tb_io_port_bank.sv
// Randomized and directed bench for io_port_bank against a cycle-level behavioural model.
// Expectations follow the build: IO_PORT_BANK_EDGE_IRQ_EN selects whether EDGE/MASK/irq are live.
module tb_io_port_bank;

    localparam int          W = 8;
    localparam int          N = 4;
    localparam logic [31:0] B = 32'h800;
`ifdef IO_PORT_BANK_EDGE_IRQ_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic           clk    = 1'b0;
    logic           resetE = 1'b0;
    logic           we     = 1'b0;
    logic           re     = 1'b0;
    logic [31:0]    addr   = 32'd0;
    logic [31:0]    wdata  = 32'd0;
    logic [N*W-1:0] pin_in = '0;
    logic [31:0]    rdata;
    logic           sel;
    logic [N*W-1:0] pin_out;
    logic           irq;

    int errors = 0;
    int checks = 0;

    io_port_bank #(.WIDTH(W), .NCH(N), .BASE(B)) dut (
        .clk(clk), .resetE(resetE), .we(we), .re(re), .addr(addr), .wdata(wdata),
        .rdata(rdata), .sel(sel), .pin_in(pin_in), .pin_out(pin_out), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference state: register contents per channel plus the pin samples taken at each edge.
    logic [31:0] outM[N];
    logic [31:0] maskM[N];
    logic [31:0] edgeM[N];
    logic        irqM;
    logic [31:0] hist[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pin value sampled 'back' edges ago (1 = most recent); samples before reset release are 0.
    function automatic logic [31:0] samp(int back);
        if (hist.size() >= back) return hist[hist.size() - back];
        return 32'd0;
    endfunction

    function automatic bit inWindow(logic [31:0] a);
        return (a >= B) && (a < B + 32'(16 * N));
    endfunction

    function automatic int chOf(logic [31:0] a);
        return int'((a >> 4) & 32'(N - 1));
    endfunction

    function automatic logic [31:0] modelRead(logic [31:0] a);
        int ch;
        if (!inWindow(a)) return 32'd0;
        ch = chOf(a);
        case (a[3:2])
            2'd0:    return outM[ch];
            2'd1:    return (samp(2) >> (ch * W)) & 32'hFF;
            2'd2:    return edgeM[ch];
            default: return maskM[ch];
        endcase
    endfunction

    function automatic logic [31:0] modelPins();
        logic [31:0] v;
        v = 32'd0;
        for (int c = 0; c < N; c++) v = v | (outM[c] << (c * W));
        return v;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < N; c++) begin
            outM[c]  = 32'd0;
            maskM[c] = 32'd0;
            edgeM[c] = 32'd0;
        end
        irqM = 1'b0;
        hist.delete();
    endtask

    // One rising clock edge with the given bus and pin inputs.
    task automatic modelEdge(input bit weV, input logic [31:0] aV, input logic [31:0] dV,
                             input logic [31:0] pV);
        int  ch;
        bit  hit;
        ch  = chOf(aV);
        hit = weV && inWindow(aV);
`ifdef IO_PORT_BANK_EDGE_IRQ_EN
        begin
            logic [31:0] rise;
            logic [31:0] clr;
            bit          nextIrq;
            rise    = samp(2) & ~samp(3);
            nextIrq = 1'b0;
            for (int c = 0; c < N; c++) if ((edgeM[c] & maskM[c]) != 0) nextIrq = 1'b1;
            for (int c = 0; c < N; c++) begin
                clr = (hit && aV[3:2] == 2'd2 && c == ch) ? (dV & 32'hFF) : 32'd0;
                edgeM[c] = (edgeM[c] & ~clr) | ((rise >> (c * W)) & 32'hFF);
            end
            if (hit && aV[3:2] == 2'd3) maskM[ch] = dV & 32'hFF;
            irqM = nextIrq;
        end
`else
        irqM = 1'b0;
`endif
        if (hit && aV[3:2] == 2'd0) outM[ch] = dV & 32'hFF;
        hist.push_back(pV);
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    task automatic applyStimulus(input bit weV, input logic [31:0] aV, input logic [31:0] dV,
                                 input logic [31:0] pV);
        @(negedge clk);
        we = weV; addr = aV; wdata = dV; pin_in = pV;
        #1;
        checkOutput("sel", {31'b0, sel}, {31'b0, inWindow(aV)});
        checkOutput("rdata", rdata, modelRead(aV));
        @(posedge clk);
        modelEdge(weV, aV, dV, pV);
        #1;
        checkOutput("pin_out", pin_out, modelPins());
        checkOutput("irq", {31'b0, irq}, {31'b0, irqM});
    endtask

    task automatic peekRead(input string tag, input logic [31:0] a, input logic [31:0] exp);
        we = 1'b0; addr = a;
        #1;
        checkOutput(tag, rdata, exp);
    endtask

    task automatic resetDut();
        resetE = 1'b0; we = 1'b0; pin_in = '0; addr = B;
        @(posedge clk);
        #1;
        checkOutput("rst_pin_out", pin_out, 32'd0);
        checkOutput("rst_irq", {31'b0, irq}, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        resetE = 1'b1;
        modelReset();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] pinCur;
        logic [31:0] aR;

        modelReset();
        resetDut();

        // Store to channel 1 OUT: only the low byte lands, other channels stay clear.
        applyStimulus(1'b1, 32'h810, 32'hFFFF_FF5A, 32'd0);
        checkOutput("out_pins", pin_out, 32'h0000_5A00);
        peekRead("out_read", 32'h810, 32'h0000_005A);
        peekRead("out_other", 32'h800, 32'h0);

        // Input path on channel 3 with two-cycle IN latency and three-cycle EDGE.
        resetDut();
        applyStimulus(1'b0, 32'h834, 32'd0, 32'h8100_0000);
        applyStimulus(1'b0, 32'h834, 32'd0, 32'h8100_0000);
        peekRead("in_lat2", 32'h834, 32'h81);
        peekRead("edge_early", 32'h838, 32'h0);
        applyStimulus(1'b0, 32'h838, 32'd0, 32'h8100_0000);
        peekRead("edge_lat3", 32'h838, EN ? 32'h81 : 32'h0);
        applyStimulus(1'b1, 32'h838, 32'h01, 32'h8100_0000);
        peekRead("edge_w1c", 32'h838, EN ? 32'h80 : 32'h0);

        // Interrupt through MASK on channel 0 bit 2.
        resetDut();
        applyStimulus(1'b1, 32'h80C, 32'h04, 32'h0);
        applyStimulus(1'b0, 32'h800, 32'h0, 32'h4);
        applyStimulus(1'b0, 32'h800, 32'h0, 32'h4);
        applyStimulus(1'b0, 32'h800, 32'h0, 32'h4);
        checkOutput("irq_pre", {31'b0, irq}, 32'h0);
        peekRead("irq_edge", 32'h808, EN ? 32'h4 : 32'h0);
        peekRead("mask_read", 32'h80C, EN ? 32'h4 : 32'h0);
        applyStimulus(1'b0, 32'h800, 32'h0, 32'h4);
        checkOutput("irq_rise", {31'b0, irq}, {31'b0, EN});
        applyStimulus(1'b1, 32'h808, 32'h04, 32'h4);
        applyStimulus(1'b0, 32'h800, 32'h0, 32'h4);
        checkOutput("irq_drop", {31'b0, irq}, 32'h0);

        // Rising edge on bit 0 in the same cycle as a W1C of that bit.
        resetDut();
        applyStimulus(1'b0, 32'h800, 32'h0, 32'h1);
        applyStimulus(1'b0, 32'h800, 32'h0, 32'h1);
        applyStimulus(1'b1, 32'h808, 32'h01, 32'h1);
        peekRead("collision", 32'h808, EN ? 32'h1 : 32'h0);

        // Just below and just above the window, using offsets that would alias MASK/OUT.
        applyStimulus(1'b1, 32'h820, 32'h3C, 32'h1);
        applyStimulus(1'b1, 32'h7FC, 32'hFF, 32'h1);
        applyStimulus(1'b1, 32'h840, 32'hFF, 32'h1);
        checkOutput("oow_pins", pin_out, 32'h003C_0000);
        peekRead("oow_lo", 32'h7FC, 32'h0);
        checkOutput("oow_sel_lo", {31'b0, sel}, 32'h0);
        peekRead("oow_hi", 32'h840, 32'h0);
        checkOutput("oow_sel_hi", {31'b0, sel}, 32'h0);
        peekRead("oow_mask0", 32'h80C, 32'h0);

        // Random traffic around and inside the window.
        pinCur = 32'd0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) pinCur = pinCur ^ $urandom;
            aR = B - 32'd16 + 32'($urandom_range(0, 16 * N + 31));
            applyStimulus(1'($urandom_range(0, 1)), aR, $urandom, pinCur);
        end

        // Asynchronous reset between clock edges, discarding a write in flight.
        applyStimulus(1'b1, 32'h800, 32'hA5, pinCur);
        @(negedge clk);
        we = 1'b1; addr = 32'h804 - 32'h4; wdata = 32'h33; pin_in = '0;
        #2;
        resetE = 1'b0;
        #1;
        checkOutput("async_rst", pin_out, 32'h0);
        checkOutput("async_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rst_write", pin_out, 32'h0);
        @(negedge clk);
        we = 1'b0;
        resetE = 1'b1;
        modelReset();
        applyStimulus(1'b0, 32'h800, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_port_bank.md
IO_PORT_BANK -- requirements
Module: io_port_bank

Interface
REQ-001 Parameter WIDTH, default 8: bits per channel, range 1..32.
REQ-002 Parameter NCH, default 4: number of channels, power of two, range 1..8.
REQ-003 Parameter BASE, default 32'h800: byte base address of the bank, 16-byte aligned.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 resetE  input  1  asynchronous, active-low reset.
REQ-006 we  input  1  processor store strobe (MemWrite).
REQ-007 re  input  1  processor load strobe (MemtoReg).
REQ-008 addr  input  32  byte address (ALU result).
REQ-009 wdata  input  32  store data.
REQ-010 rdata  output  32  load data, zero-extended, combinational.
REQ-011 sel  output  1  high when addr is inside the bank window; drives the read-data mux.
REQ-012 pin_in  input  NCH*WIDTH  external inputs; channel i is bits [i*WIDTH +: WIDTH].
REQ-013 pin_out  output  NCH*WIDTH  registered outputs, same packing.
REQ-014 irq  output  1  level interrupt request.

Function
REQ-015 Bank window = BASE .. BASE+16*NCH-1.
- sel = 1 inside the window, 0 outside.
- Channel index = addr[4 +: log2(NCH)].
- Register offset = addr[3:2].
- addr[1:0] are ignored.
REQ-016 Register map per channel; unused upper rdata bits read 0.
- +0x0 OUT: read/write.
- +0x4 IN: read-only; writes ignored.
- +0x8 EDGE: sticky status, write-1-to-clear.
- +0xC MASK: read/write interrupt mask.
REQ-017 A write occurs only when we=1 and sel=1.
- Only wdata[WIDTH-1:0] is used.
- Takes effect at the next rising clk edge.
- pin_out reflects an OUT write one cycle after the write cycle.
REQ-018 rdata = selected register when sel=1, otherwise 0.
- re does not gate rdata; reads have no side effects.
REQ-019 Each pin_in bit passes through a two-flop synchronizer (s1, s2) and a history flop s3.
- IN reads s2, giving two cycles of latency from a pin change.
REQ-020 Rising edge on bit b = s2[b] & ~s3[b]. An edge sets EDGE[b] on that clock edge.
REQ-021 Simultaneous edge-set and W1C clear of the same EDGE bit: set wins and the bit stays 1.
REQ-022 irq = OR over all channels of (EDGE & MASK).
- Registered; asserts one cycle after the contributing EDGE or MASK bit becomes 1.
REQ-023 Writing OUT does not affect IN or EDGE; there is no internal loopback.
REQ-024 Outside the window: writes are ignored, rdata=0, sel=0, and no state changes.

Reset
REQ-025 resetE=0 asynchronously clears all of the following; outputs are 0 while reset is held:
- OUT, MASK, EDGE
- s1, s2, s3
- irq, pin_out
REQ-026 Reset asserted mid-operation, including during an active write cycle, discards the write.
REQ-027 After release, a pin held high sets its EDGE bit on the third rising edge (s3 reset to 0).

Configuration
REQ-028 Macro IO_PORT_BANK_EDGE_IRQ_EN controls edge detection and interrupts.
- Defined: the EDGE and MASK registers, s3, and irq are implemented as specified.
- Undefined: EDGE and MASK read 0, writes to them are ignored, irq is tied to 0, and s3 is omitted.
- OUT and IN behaviour is identical in both builds.

Verification (WIDTH=8, NCH=4, BASE=0x800, macro defined unless stated)
REQ-029 Write: we=1, addr=0x810, wdata=0xFFFF_FF5A.
- pin_out[15:8]=0x5A on the following cycle.
- A read of 0x810 returns 0x0000_005A.
- Other channels remain 0.
REQ-030 Input path: pin_in[31:24] steps 0x00 to 0x81.
- A read of 0x834 returns 0x81 exactly two cycles later.
- EDGE at 0x838 reads 0x81 at three cycles.
- Write 0x01 to 0x838: EDGE then reads 0x80.
REQ-031 Interrupt: write MASK 0x80C=0x04, then raise pin_in[2].
- irq rises one cycle after EDGE[2] sets.
- W1C 0x04 to 0x808 drops irq the following cycle.
REQ-032 Collision: rising edge on pin_in[0] in the same cycle as a W1C of 0x01 to 0x808 -> EDGE[0] remains 1.
REQ-033 Out of window: accesses to 0x7FC and 0x840 give sel=0 and rdata=0, and no register changes.
- Reset mid-run clears pin_out to 0x0000_0000 immediately, without waiting for clk.
REQ-034 Build without the macro: pin edges and MASK writes -> irq stays 0, and 0x808 and 0x80C read 0.
